// File: rtl/regfile_dump_ctrl.sv
// Register-file dump controller: walks every register and streams its
// bytes, LSB first, to a valid/ready byte transmitter while halted.
module regfile_dump_ctrl #(
   parameter int NB_REG  = 32,
   parameter int NB_ADDR = 5,
   parameter int NB_BYTE = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_halted,
   output logic               o_rd_en,
   output logic [NB_ADDR-1:0] o_rd_addr,
   input  logic [NB_REG-1:0]  i_rd_data,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_abort
);

   localparam int NB_BYTES = NB_REG / NB_BYTE;
   localparam int NB_BIDX  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
   localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(NB_BYTES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_SEND,
      ST_DONE,
      ST_ABORT
   } state_t;

   state_t               state_q, state_d;
   logic [NB_ADDR-1:0]   reg_idx_q, reg_idx_d;
   logic [NB_BIDX-1:0]   byte_idx_q, byte_idx_d;
   logic [NB_REG-1:0]    shift_q, shift_d;
   logic                 rd_en_q, rd_en_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 abort_q, abort_d;

   always_comb begin
      state_d    = state_q;
      reg_idx_d  = reg_idx_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;

      unique case (state_q)
         ST_IDLE: begin
            if (i_start && i_halted) begin
               reg_idx_d  = '0;
               byte_idx_d = '0;
               state_d    = ST_READ;
            end
         end
         ST_READ: begin
            if (!i_halted) begin
               state_d = ST_ABORT;
            end else begin
               shift_d    = i_rd_data;
               byte_idx_d = '0;
               state_d    = ST_SEND;
            end
         end
         ST_SEND: begin
            // losing halt beats a same-cycle handshake: the byte is dropped
            if (!i_halted) begin
               state_d = ST_ABORT;
            end else if (i_tx_ready) begin
               shift_d = shift_q >> NB_BYTE;
               if (byte_idx_q == LAST_BYTE) begin
                  if (reg_idx_q == '1) begin
                     state_d = ST_DONE;
                  end else begin
                     reg_idx_d = reg_idx_q + NB_ADDR'(1);
                     state_d   = ST_READ;
                  end
               end else begin
                  byte_idx_d = byte_idx_q + NB_BIDX'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         ST_ABORT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (i_reset) begin
         state_d    = ST_IDLE;
         reg_idx_d  = '0;
         byte_idx_d = '0;
         shift_d    = '0;
      end

      // outputs are decoded from the next state so they leave a flop
      rd_en_d    = (state_d == ST_READ) || (state_d == ST_SEND);
      tx_valid_d = (state_d == ST_SEND);
      busy_d     = (state_d != ST_IDLE);
      done_d     = (state_d == ST_DONE);
      abort_d    = (state_d == ST_ABORT);
   end

   always_ff @(posedge i_clk) begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      rd_en_q    <= rd_en_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
   end

   assign o_rd_en    = rd_en_q;
   assign o_rd_addr  = reg_idx_q;
   assign o_tx_data  = shift_q[NB_BYTE-1:0];
   assign o_tx_valid = tx_valid_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_abort    = abort_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: directed and random dumps checked
// against a byte-stream model derived from the register array.
module tb_regfile_dump_ctrl;

   localparam int NB_REG   = 32;
   localparam int NB_ADDR  = 5;
   localparam int NB_BYTE  = 8;
   localparam int NREGS    = 1 << NB_ADDR;
   localparam int NBYTES   = NB_REG / NB_BYTE;
   localparam int NTOTAL   = NREGS * NBYTES;
   localparam int BUDGET   = 3000;

   logic               clk = 1'b0;
   logic               i_reset = 1'b1;
   logic               i_start = 1'b0;
   logic               i_halted = 1'b1;
   logic               o_rd_en;
   logic [NB_ADDR-1:0] o_rd_addr;
   logic [NB_REG-1:0]  i_rd_data;
   logic [NB_BYTE-1:0] o_tx_data;
   logic               o_tx_valid;
   logic               i_tx_ready = 1'b0;
   logic               o_busy;
   logic               o_done;
   logic               o_abort;

   logic [NB_REG-1:0]  rf [NREGS];
   logic [NB_BYTE-1:0] got [$];
   int total = 0;
   int bad = 0;
   int n_done, n_abort, done_cyc, first_valid, cyc;

   always #5 clk = ~clk;

   assign i_rd_data = rf[o_rd_addr];

   regfile_dump_ctrl #(
      .NB_REG (NB_REG),
      .NB_ADDR(NB_ADDR),
      .NB_BYTE(NB_BYTE)
   ) dut (
      .i_clk     (clk),
      .i_reset   (i_reset),
      .i_start   (i_start),
      .i_halted  (i_halted),
      .o_rd_en   (o_rd_en),
      .o_rd_addr (o_rd_addr),
      .i_rd_data (i_rd_data),
      .o_tx_data (o_tx_data),
      .o_tx_valid(o_tx_valid),
      .i_tx_ready(i_tx_ready),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_abort   (o_abort)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NB_BYTE-1:0] exp_byte(input int i);
      logic [NB_REG-1:0] w;
      w = rf[i / NBYTES];
      return NB_BYTE'(w >> (NB_BYTE * (i % NBYTES)));
   endfunction

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_rd_en"}, 32'(o_rd_en), 0);
      chk({tag, "_rd_addr"}, 32'(o_rd_addr), 0);
      chk({tag, "_tx_data"}, 32'(o_tx_data), 0);
      chk({tag, "_tx_valid"}, 32'(o_tx_valid), 0);
      chk({tag, "_busy"}, 32'(o_busy), 0);
      chk({tag, "_done"}, 32'(o_done), 0);
      chk({tag, "_abort"}, 32'(o_abort), 0);
   endtask

   task automatic chk_stream(input string tag);
      chk({tag, "_count"}, 32'(got.size()), NTOTAL);
      for (int i = 0; i < got.size() && i < NTOTAL; i++)
         chk({tag, "_byte"}, 32'(got[i]), 32'(exp_byte(i)));
   endtask

   // mode 0: ready high, 1: one on / two off, 2: random
   task automatic run_dump(input int mode, input bit restart);
      logic               pv, pr, rdy;
      logic [NB_BYTE-1:0] pd;
      got.delete();
      n_done = 0;
      n_abort = 0;
      done_cyc = -1;
      first_valid = -1;
      pv = 1'b0;
      pr = 1'b0;
      pd = '0;
      i_tx_ready = 1'b1;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      cyc = 0;
      while (cyc < BUDGET) begin
         if (o_done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (o_abort) n_abort++;
         if (o_tx_valid && first_valid < 0) first_valid = cyc;
         if (pv && !pr) begin
            chk("stall_valid", 32'(o_tx_valid), 1);
            chk("stall_data", 32'(o_tx_data), 32'(pd));
         end
         if (o_tx_valid) begin
            chk("send_rd_en", 32'(o_rd_en), 1);
            chk("send_rd_addr", 32'(o_rd_addr), 32'(got.size() / NBYTES));
         end
         if (cyc > 0 && !o_busy) break;
         case (mode)
            0: rdy = 1'b1;
            1: rdy = (cyc % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         i_tx_ready = rdy;
         i_start = restart && (cyc == 50 || cyc == 51);
         if (o_tx_valid && rdy) got.push_back(o_tx_data);
         pv = o_tx_valid;
         pr = rdy;
         pd = o_tx_data;
         step();
         cyc++;
      end
      i_start = 1'b0;
      chk("dump_in_budget", 32'(cyc < BUDGET), 1);
      chk("dump_one_done", 32'(n_done), 1);
      chk("dump_no_abort", 32'(n_abort), 0);
      chk("done_low_after", 32'(o_done), 0);
   endtask

   initial begin
      int found;
      for (int n = 0; n < NREGS; n++) rf[n] = 32'h100 * n + n;

      repeat (2) step();
      chk_zero_outputs("reset");
      i_reset = 1'b0;
      step();
      chk_zero_outputs("idle");

      run_dump(0, 1'b0);
      chk_stream("fast");
      chk("first_valid_e1", 32'(first_valid), 1);
      chk("done_at_e160", 32'(done_cyc), 5 * NREGS);
      if (got.size() >= 8) begin
         chk("b0", 32'(got[0]), 0);
         chk("b3", 32'(got[3]), 0);
         chk("b4", 32'(got[4]), 8'h01);
         chk("b5", 32'(got[5]), 8'h01);
         chk("b6", 32'(got[6]), 0);
         chk("b7", 32'(got[7]), 0);
      end

      run_dump(1, 1'b0);
      chk_stream("toggle");

      run_dump(0, 1'b1);
      chk_stream("restart");

      for (int n = 0; n < NREGS; n++) rf[n] = $urandom;
      run_dump(2, 1'b0);
      chk_stream("random");

      i_halted = 1'b0;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         chk("nohalt_busy", 32'(o_busy), 0);
         chk("nohalt_valid", 32'(o_tx_valid), 0);
         step();
      end
      i_halted = 1'b1;

      i_tx_ready = 1'b1;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      found = 0;
      n_done = 0;
      got.delete();
      for (int k = 0; k < BUDGET; k++) begin
         if (o_done) n_done++;
         if (o_tx_valid && got.size() == 7 * NBYTES + 2) begin
            found = 1;
            break;
         end
         if (o_tx_valid) got.push_back(o_tx_data);
         step();
      end
      chk("abort_reached", 32'(found), 1);
      chk("abort_byte", 32'(o_tx_data), 32'(exp_byte(7 * NBYTES + 2)));
      i_halted = 1'b0;
      step();
      chk("abort_pulse", 32'(o_abort), 1);
      chk("abort_valid", 32'(o_tx_valid), 0);
      chk("abort_rd_en", 32'(o_rd_en), 0);
      chk("abort_no_done", 32'(o_done), 0);
      step();
      chk("abort_once", 32'(o_abort), 0);
      chk("abort_busy", 32'(o_busy), 0);
      chk("abort_prior_done", 32'(n_done), 0);
      i_halted = 1'b1;
      step();

      i_start = 1'b1;
      step();
      i_start = 1'b0;
      found = 0;
      for (int k = 0; k < BUDGET; k++) begin
         if (o_rd_en && !o_tx_valid && o_rd_addr == 12) begin
            found = 1;
            break;
         end
         step();
      end
      chk("rst_reached", 32'(found), 1);
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      chk_zero_outputs("midrst");
      step();
      chk("midrst_done", 32'(o_done), 0);
      chk("midrst_abort", 32'(o_abort), 0);
      run_dump(0, 1'b0);
      chk_stream("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
